// File: rtl/ov7670_pkg.sv
// Shared types, defaults and pixel repack helper for the OV7670 capture path.
package ov7670_pkg;

  localparam int unsigned H_RES_DEF    = 640;
  localparam int unsigned V_RES_DEF    = 480;
  localparam int unsigned FRAME_PIXELS = H_RES_DEF * V_RES_DEF;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned PIX_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  // Folds a camera byte pair into one {R,G,B} 4:4:4 pixel.
  function automatic logic [PIX_W-1:0] repack(input logic [7:0] b0,
                                               input logic [7:0] b1,
                                               input bit         rgb565);
    if (rgb565) begin
      return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    end
    return {b0[3:0], b1};
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera input bus and frame-RAM write stream of the capture block.
interface ov7670_capture_if;
  import ov7670_pkg::*;

  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              capture_en;
  logic [ADDR_W-1:0] frame_addr;
  logic [PIX_W-1:0]  frame_pixel;
  logic              we;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              err_overflow;
  logic              err_line;

  // Camera / control side.
  modport master (
    output vsync, href, d, capture_en,
    input  frame_addr, frame_pixel, we, frame_done, frame_cnt, err_overflow, err_line
  );

  // Capture core side.
  modport slave (
    input  vsync, href, d, capture_en,
    output frame_addr, frame_pixel, we, frame_done, frame_cnt, err_overflow, err_line
  );

endinterface

// File: rtl/ov7670_byte_pack.sv
// Byte phase tracking, first-byte latch and registered pixel/write strobe.
module ov7670_byte_pack
  import ov7670_pkg::*;
#(
  parameter bit RGB565 = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             allow_i,
  input  logic             href_i,
  input  logic [7:0]       d_i,
  output logic             phase_o,
  output logic             we_o,
  output logic [PIX_W-1:0] pixel_o
);

  logic             phase_q, phase_d;
  logic             we_q, we_d;
  logic [7:0]       b0_q, b0_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  // Phase toggles per valid byte; pixel is held between writes.
  always_comb begin
    phase_d = href_i & ~phase_q & ~clr_i;
    b0_d    = b0_q;
    pixel_d = pixel_q;
    we_d    = href_i & phase_q & allow_i;
    if (href_i && !phase_q) begin
      b0_d = d_i;
    end
    if (we_d) begin
      pixel_d = repack(b0_q, d_i, RGB565);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      b0_q    <= 8'd0;
      pixel_q <= '0;
    end else begin
      phase_q <= phase_d;
      we_q    <= we_d;
      b0_q    <= b0_d;
      pixel_q <= pixel_d;
    end
  end

  assign phase_o = phase_q;
  assign we_o    = we_q;
  assign pixel_o = pixel_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: frame FSM, pixel/line counters and error flags.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DEF,
  parameter int unsigned V_RES  = V_RES_DEF,
  parameter bit          RGB565 = 1'b0,
  parameter int unsigned SKIP   = 0
) (
  input logic             pclk,
  input logic             rst,
  ov7670_capture_if.slave cam
);

  localparam int unsigned FRAME_PIX = H_RES * V_RES;
  localparam int unsigned LPW       = $clog2(H_RES + 1);
  localparam int unsigned LCW       = $clog2(V_RES + 1);
  localparam int unsigned SKW       = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  cap_state_e        state_q;
  logic              vsync_q, href_q;
  logic [SKW-1:0]    skip_q;
  logic [ADDR_W-1:0] pix_idx_q, frame_addr_q;
  logic [LPW-1:0]    line_pix_q;
  logic [LCW-1:0]    line_cnt_q;
  logic              frame_done_q, err_ovf_q, err_line_q;
  logic [7:0]        frame_cnt_q;

  logic              bp_phase, bp_we;
  logic [PIX_W-1:0]  bp_pixel;
  logic              vs_rise, vs_fall, href_fall, active, room, pair, start, allow;

  // Edge detects and write qualification.
  assign vs_rise   = cam.vsync & ~vsync_q;
  assign vs_fall   = ~cam.vsync & vsync_q;
  assign href_fall = href_q & ~cam.href;
  assign active    = (state_q == ST_ACTIVE);
  assign room      = (pix_idx_q < ADDR_W'(FRAME_PIX));
  assign pair      = active & ~vs_rise & cam.href & bp_phase;
  assign allow     = active & ~vs_rise & room;
  assign start     = (state_q == ST_ARMED) & cam.capture_en & vs_fall & (skip_q == '0);

  ov7670_byte_pack #(.RGB565(RGB565)) u_pack (
    .clk_i   (pclk),
    .rst_i   (rst),
    .clr_i   (start),
    .allow_i (allow),
    .href_i  (cam.href),
    .d_i     (cam.d),
    .phase_o (bp_phase),
    .we_o    (bp_we),
    .pixel_o (bp_pixel)
  );

  // Frame FSM with counters and sticky error flags.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      skip_q       <= '0;
      pix_idx_q    <= '0;
      frame_addr_q <= '0;
      line_pix_q   <= '0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_ovf_q    <= 1'b0;
      err_line_q   <= 1'b0;
    end else begin
      vsync_q      <= cam.vsync;
      href_q       <= cam.href;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cam.vsync && cam.capture_en) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!cam.capture_en) begin
            state_q <= ST_IDLE;
          end else if (vs_fall) begin
            if (skip_q != '0) begin
              skip_q  <= skip_q - SKW'(1);
              state_q <= ST_IDLE;
            end else begin
              skip_q     <= SKW'(SKIP);
              pix_idx_q  <= '0;
              line_pix_q <= '0;
              line_cnt_q <= '0;
              state_q    <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          if (vs_rise) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 8'd1;
            if (line_cnt_q != LCW'(V_RES)) begin
              err_line_q <= 1'b1;
            end
          end else begin
            if (pair) begin
              if (room) begin
                frame_addr_q <= pix_idx_q;
                pix_idx_q    <= pix_idx_q + ADDR_W'(1);
              end else begin
                err_ovf_q <= 1'b1;
              end
              if (line_pix_q != '1) begin
                line_pix_q <= line_pix_q + LPW'(1);
              end
            end
            if (href_fall) begin
              if (line_pix_q != LPW'(H_RES)) begin
                err_line_q <= 1'b1;
              end
              line_pix_q <= '0;
              if (line_cnt_q != '1) begin
                line_cnt_q <= line_cnt_q + LCW'(1);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cam.frame_addr   = frame_addr_q;
  assign cam.frame_pixel  = bp_pixel;
  assign cam.we           = bp_we;
  assign cam.frame_done   = frame_done_q;
  assign cam.frame_cnt    = frame_cnt_q;
  assign cam.err_overflow = err_ovf_q;
  assign cam.err_line     = err_line_q;

endmodule
